digit_scan_ctrl: RTL
====================

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 Parameter: DIV_W, default 16, width of dwell-length input div.
REQ-002 Parameter: BLANK_CYC, default 2, blanking cycles between digits; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: run  input  1  level; 1 = scan digits, 0 = stop after current digit.
REQ-006 Port: div  input  DIV_W  dwell per digit minus one, in clk cycles.
REQ-007 Port: en  output  1  decoder enable, registered.
REQ-008 Port: a  output  3  digit index to 3-to-6 decoder, registered, range 0..5 only.
REQ-009 Port: wrap  output  1  one-cycle pulse marking end of digit 5.
REQ-010 Port: busy  output  1  1 whenever state is not IDLE.

Function
REQ-011 States SHALL be IDLE, BLANK, SHOW; all outputs SHALL be registered.
REQ-012 IDLE: en=0, a=0, wrap=0, busy=0; run sampled 1 -> BLANK on next edge.
REQ-013 BLANK: en=0, a held; lasts exactly BLANK_CYC cycles, then SHOW.
REQ-014 On BLANK->SHOW transition, div SHALL be captured; changes to div during SHOW SHALL have no effect until the next digit.
REQ-015 SHOW: en=1, a held; lasts exactly captured div+1 cycles (div=0 -> 1 cycle; div=all-ones -> 2^DIV_W cycles).
REQ-016 At end of SHOW with run=1: a increments, 5 -> 0 wrap-around, state -> BLANK.
REQ-017 At end of SHOW with run=0: state -> IDLE, a -> 0; run deassertion SHALL never truncate a SHOW or BLANK interval.
REQ-018 run deasserted then reasserted within a digit slot SHALL leave scanning uninterrupted.
REQ-019 wrap SHALL be 1 exactly during the last SHOW cycle of digit 5, else 0.
REQ-020 a SHALL never take values 6 or 7; en=1 only in SHOW.
REQ-021 Latency: run sampled high at edge N -> en=1, a=0 from edge N+BLANK_CYC+1.
REQ-022 Digit period SHALL be BLANK_CYC+div+1 cycles; frame period 6x that for constant div.

Reset
REQ-023 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, en=0, a=0, wrap=0, busy=0, counters=0.
REQ-024 Reset asserted mid-SHOW or mid-BLANK SHALL abort the slot; after release, operation resumes per REQ-012 from digit 0.
REQ-025 First edge after rst_n release SHALL be treated as a normal IDLE cycle.

Structure
REQ-026 Shared package SHALL hold state encodings (IDLE, BLANK, SHOW), NUM_DIGITS=6, and LAST_DIGIT=5.
REQ-027 One sub-module, dwell_counter (loadable down-counter, DIV_W wide, terminal-count output), SHALL time both BLANK and SHOW intervals.

Verification
REQ-028 Reset: rst_n=0 during SHOW a=3 -> en=0, a=0, busy=0 same cycle, no clock needed.
REQ-029 Basic scan: BLANK_CYC=2, div=3, run=1 at edge 0 -> en=0 edges 1-2, en=1 a=0 edges 3-6, en=0 a=1 edges 7-8, en=1 a=1 edges 9-12.
REQ-030 Wrap: same settings, run held -> a sequence 0,1,2,3,4,5,0; wrap=1 for one cycle, at edge 36 (last SHOW cycle of digit 5); frame period 36 cycles.
REQ-031 Stop: run=0 mid-SHOW of a=2 -> SHOW completes full 4 cycles, then IDLE, a=0, busy=0; no BLANK for a=3.
REQ-032 Div boundaries: div=0 -> single-cycle en pulses per digit; div changed 3->7 mid-SHOW -> current digit 4 cycles, next digit 8 cycles.
REQ-033 Invariant check throughout all tests: a<=5, en implies state SHOW, wrap implies a=5 and en=1.

Source files
------------

// File: rtl/digit_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan_ctrl_pkg
//  Description : Shared definitions for the 6-digit scan controller.
//                State encodings, digit-count constants and a digit
//                increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package digit_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam int         NUM_DIGITS = 6;
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

  // Advance a digit index with wrap-around after the last digit, so the
  // decoder address can never reach 6 or 7.
  function automatic logic [2:0] next_digit(input logic [2:0] d);
    return (d >= LAST_DIGIT) ? 3'd0 : d + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_scan_ctrl_dwell.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_counter
//  Description : Loadable down-counter with terminal-count flags. A loaded
//                value N makes the count reach zero N cycles later, so an
//                interval started with a load of N lasts N+1 cycles.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                load_i          - load load_val_i on the next edge
//                load_val_i      - value to load (interval length minus one)
//                tc_o            - count is currently zero
//                tc_next_o       - count will be zero after the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
module dwell_counter #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             tc_o,
  output logic             tc_next_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o      = (cnt_q == '0);
  // Lets the parent register an output that must be valid during the final
  // cycle of an interval.
  assign tc_next_o = (cnt_d == '0);

endmodule
`default_nettype wire

// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan_ctrl
//  Description : Scans a 6-digit multiplexed display. Each digit slot is a
//                BLANK gap of BLANK_CYC cycles followed by a SHOW interval of
//                div+1 cycles. All outputs are registered.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset
//                run    - 1 = keep scanning, 0 = stop after current digit
//                div    - SHOW dwell minus one, captured at BLANK->SHOW
//                en     - decoder enable (high only in SHOW)
//                a      - digit index 0..5
//                wrap   - high during the last SHOW cycle of digit 5
//                busy   - controller not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_scan_ctrl #(
  parameter int DIV_W     = 16,
  parameter int BLANK_CYC = 2    // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             en,
  output logic [2:0]       a,
  output logic             wrap,
  output logic             busy
);

  import digit_scan_ctrl_pkg::*;

  localparam logic [DIV_W-1:0] BLANK_LOAD = DIV_W'(BLANK_CYC - 1);

  state_e           state_q, state_d;
  logic [2:0]       a_q, a_d;
  logic             en_q, wrap_q, busy_q;
  logic             en_d, wrap_d, busy_d;
  logic             run_q;

  logic             cnt_load;
  logic [DIV_W-1:0] cnt_val;
  logic             cnt_tc;
  logic             cnt_tc_next;

  dwell_counter #(
    .DIV_W (DIV_W)
  ) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .tc_o       (cnt_tc),
    .tc_next_o  (cnt_tc_next)
  );

  // run is sampled into run_q; every decision uses the sampled level, so a
  // short drop of run inside a slot never truncates BLANK or SHOW and only
  // matters if it is still low when SHOW ends.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    cnt_load = 1'b0;
    cnt_val  = BLANK_LOAD;

    case (state_q)
      ST_IDLE: begin
        a_d = 3'd0;
        if (run_q) begin
          state_d  = ST_BLANK;
          cnt_load = 1'b1;
          cnt_val  = BLANK_LOAD;
        end
      end

      ST_BLANK: begin
        if (cnt_tc) begin
          // div is captured here and held in the counter for the whole SHOW.
          state_d  = ST_SHOW;
          cnt_load = 1'b1;
          cnt_val  = div;
        end
      end

      ST_SHOW: begin
        if (cnt_tc) begin
          if (run_q) begin
            state_d  = ST_BLANK;
            a_d      = next_digit(a_q);
            cnt_load = 1'b1;
            cnt_val  = BLANK_LOAD;
          end else begin
            state_d = ST_IDLE;
            a_d     = 3'd0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        a_d     = 3'd0;
      end
    endcase

    // Outputs are derived from the next state so the registered values line
    // up with the state they describe.
    en_d   = (state_d == ST_SHOW);
    busy_d = (state_d != ST_IDLE);
    wrap_d = (state_d == ST_SHOW) && (a_d == LAST_DIGIT) && cnt_tc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= 3'd0;
      en_q    <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      en_q    <= en_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      run_q   <= run;
    end
  end

  assign en   = en_q;
  assign a    = a_q;
  assign wrap = wrap_q;
  assign busy = busy_q;

endmodule
`default_nettype wire
